alu_wb_buffer: RTL and testbench

//  Consumer end of the execute-unit result path. Bitwise/arith units (or_module, etc.) push
//  {rd, result} via valid/ready; block queues them in a DEPTH-entry FIFO and drains one per

---
 rtl/alu_wb_buffer_pkg.sv | 24 ++
 rtl/alu_wb_buffer_if.sv | 24 ++
 rtl/alu_wb_buffer_hazard_cmp.sv | 30 +++
 rtl/alu_wb_buffer.sv | 97 +++++++++
 tb/tb_alu_wb_buffer.sv | 200 ++++++++++++++++++++
 5 files changed

// File: rtl/alu_wb_buffer_pkg.sv
// Shared execute/writeback definitions: datapath widths, zero-register index and
// occupancy classification for the writeback result FIFO.
package alu_wb_buffer_pkg;

    localparam int unsigned RISC_DATA_W = 32;
    localparam int unsigned RISC_ADDR_W = 5;
    localparam logic [RISC_ADDR_W-1:0] REG_ZERO = '0;

    typedef enum logic [1:0] {
        OCC_EMPTY,
        OCC_PARTIAL,
        OCC_FULL
    } occ_e;

    function automatic occ_e occ_of(input int unsigned cnt, input int unsigned depth);
        if (cnt == 0)
            return OCC_EMPTY;
        else if (cnt >= depth)
            return OCC_FULL;
        else
            return OCC_PARTIAL;
    endfunction

endpackage

// File: rtl/alu_wb_buffer_if.sv
// Producer-side result handshake plus register-file write port of the writeback buffer.
interface alu_wb_buffer_if #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 5
);
    logic              in_valid;
    logic [ADDR_W-1:0] in_rd;
    logic [DATA_W-1:0] in_data;
    logic              in_ready;
    logic              rf_we;
    logic [ADDR_W-1:0] rf_waddr;
    logic [DATA_W-1:0] rf_wdata;
    logic              rf_ready;

    modport slave (
        input  in_valid, in_rd, in_data, rf_ready,
        output in_ready, rf_we, rf_waddr, rf_wdata
    );

    modport master (
        output in_valid, in_rd, in_data, rf_ready,
        input  in_ready, rf_we, rf_waddr, rf_wdata
    );
endinterface

// File: rtl/alu_wb_buffer_hazard_cmp.sv
// Compares every queued destination against the decode source registers; x0 never matches.
module wb_hazard_cmp
    import alu_wb_buffer_pkg::*;
#(
    parameter int unsigned ADDR_W = RISC_ADDR_W,
    parameter int unsigned DEPTH  = 4
) (
    input  logic [DEPTH-1:0]             vld,
    input  logic [DEPTH-1:0][ADDR_W-1:0] rd,
    input  logic [ADDR_W-1:0]            rs1,
    input  logic [ADDR_W-1:0]            rs2,
    output logic                         stall
);

    logic [DEPTH-1:0] hit;
    logic             rs1_nz;
    logic             rs2_nz;

    always_comb begin
        rs1_nz = (rs1 != ADDR_W'(REG_ZERO));
        rs2_nz = (rs2 != ADDR_W'(REG_ZERO));
    end

    for (genvar i = 0; i < DEPTH; i++) begin : g_cmp
        assign hit[i] = vld[i] & (((rd[i] == rs1) & rs1_nz) | ((rd[i] == rs2) & rs2_nz));
    end

    always_comb stall = |hit;

endmodule

// File: rtl/alu_wb_buffer.sv
// Writeback result FIFO: queues {rd, result} from execute units, drains one entry per
// cycle into the register file and flags RAW hazards on queued destinations.
module alu_wb_buffer
    import alu_wb_buffer_pkg::*;
#(
    parameter int unsigned DATA_W = RISC_DATA_W,
    parameter int unsigned ADDR_W = RISC_ADDR_W,
    parameter int unsigned DEPTH  = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    flush,
    alu_wb_buffer_if.slave          bus,
    input  logic [ADDR_W-1:0]       hz_rs1,
    input  logic [ADDR_W-1:0]       hz_rs2,
    output logic                    hz_stall,
    output logic [$clog2(DEPTH):0]  count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [DEPTH-1:0][ADDR_W-1:0] rd_q;
    logic [DEPTH-1:0][DATA_W-1:0] data_q;
    logic [DEPTH-1:0]             vld_q;
    logic [DEPTH-1:0]             vld_d;
    logic [PTR_W-1:0]             wr_ptr;
    logic [PTR_W-1:0]             rd_ptr;
    logic [CNT_W-1:0]             cnt_q;
    occ_e                         occ;
    logic                         push;
    logic                         store;
    logic                         pop;

    always_comb begin
        occ          = occ_of(32'(cnt_q), DEPTH);
        bus.in_ready = (occ != OCC_FULL);
        push         = bus.in_valid & bus.in_ready;
        // x0 results complete the handshake but are never queued
        store        = push & (bus.in_rd != ADDR_W'(REG_ZERO));
        bus.rf_we    = vld_q[rd_ptr];
        bus.rf_waddr = bus.rf_we ? rd_q[rd_ptr]   : '0;
        bus.rf_wdata = bus.rf_we ? data_q[rd_ptr] : '0;
        pop          = bus.rf_we & bus.rf_ready;
    end

    always_comb begin
        vld_d = vld_q;
        if (store) vld_d[wr_ptr] = 1'b1;
        if (pop)   vld_d[rd_ptr] = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt_q  <= '0;
            vld_q  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt_q  <= '0;
            vld_q  <= '0;
        end else begin
            vld_q <= vld_d;
            if (store) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)   rd_ptr <= rd_ptr + PTR_W'(1);
            case ({store, pop})
                2'b10:   cnt_q <= cnt_q + CNT_W'(1);
                2'b01:   cnt_q <= cnt_q - CNT_W'(1);
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    // Payload storage needs no reset: it is only observed through the valid bits
    always_ff @(posedge clk) begin
        if (store && !flush) begin
            rd_q[wr_ptr]   <= bus.in_rd;
            data_q[wr_ptr] <= bus.in_data;
        end
    end

    wb_hazard_cmp #(
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH)
    ) u_hazard_cmp (
        .vld   (vld_q),
        .rd    (rd_q),
        .rs1   (hz_rs1),
        .rs2   (hz_rs2),
        .stall (hz_stall)
    );

    always_comb count = cnt_q;

endmodule

// File: tb/tb_alu_wb_buffer.sv
// Self-checking bench for alu_wb_buffer against a queue-based reference model.
module tb_alu_wb_buffer;

    localparam int unsigned DW    = 32;
    localparam int unsigned AW    = 5;
    localparam int unsigned DEPTH = 4;

    typedef struct packed {
        logic [AW-1:0] rd;
        logic [DW-1:0] data;
    } ent_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          flush;
    logic [AW-1:0] hz_rs1;
    logic [AW-1:0] hz_rs2;
    logic          hz_stall;
    logic [2:0]    count;

    ent_t        q[$];
    int unsigned checks = 0;
    int unsigned errors = 0;

    alu_wb_buffer_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

    alu_wb_buffer #(
        .DATA_W (DW),
        .ADDR_W (AW),
        .DEPTH  (DEPTH)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .flush    (flush),
        .bus      (bus),
        .hz_rs1   (hz_rs1),
        .hz_rs2   (hz_rs2),
        .hz_stall (hz_stall),
        .count    (count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic expect_outputs();
        bit stall = 1'b0;
        foreach (q[i])
            if ((q[i].rd == hz_rs1 && hz_rs1 != 0) || (q[i].rd == hz_rs2 && hz_rs2 != 0))
                stall = 1'b1;
        chk("in_ready", 64'(bus.in_ready), 64'(q.size() != DEPTH));
        chk("rf_we",    64'(bus.rf_we),    64'(q.size() != 0));
        chk("rf_waddr", 64'(bus.rf_waddr), (q.size() != 0) ? 64'(q[0].rd)   : 64'd0);
        chk("rf_wdata", 64'(bus.rf_wdata), (q.size() != 0) ? 64'(q[0].data) : 64'd0);
        chk("count",    64'(count),        64'(q.size()));
        chk("hz_stall", 64'(hz_stall),     64'(stall));
    endtask

    // Drive one cycle at the falling edge, check, then apply the reference rules at the rising edge
    task automatic cycle(input logic v, input logic [AW-1:0] rd, input logic [DW-1:0] d,
                         input logic rdy, input logic fl,
                         input logic [AW-1:0] r1, input logic [AW-1:0] r2);
        bit   push;
        bit   pop;
        ent_t e;
        bus.in_valid = v;
        bus.in_rd    = rd;
        bus.in_data  = d;
        bus.rf_ready = rdy;
        flush        = fl;
        hz_rs1       = r1;
        hz_rs2       = r2;
        #1;
        expect_outputs();
        push = v && (q.size() != DEPTH) && (rd != 0);
        pop  = (q.size() != 0) && rdy;
        @(posedge clk);
        if (fl) begin
            q.delete();
        end else begin
            if (pop) q.delete(0);
            if (push) begin
                e.rd   = rd;
                e.data = d;
                q.push_back(e);
            end
        end
        @(negedge clk);
        #1;
    endtask

    initial begin
        rst          = 1'b1;
        flush        = 1'b0;
        hz_rs1       = '0;
        hz_rs2       = '0;
        bus.in_valid = 1'b0;
        bus.in_rd    = '0;
        bus.in_data  = '0;
        bus.rf_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        expect_outputs();
        rst = 1'b0;

        // Single entry: one-cycle latency, then drained
        cycle(1'b1, 5'd5, 32'hF0F0_0F0F, 1'b1, 1'b0, '0, '0);
        chk("lat_we",    64'(bus.rf_we), 64'd1);
        chk("lat_waddr", 64'(bus.rf_waddr), 64'd5);
        chk("lat_wdata", 64'(bus.rf_wdata), 64'hF0F0_0F0F);
        cycle(1'b0, '0, '0, 1'b1, 1'b0, '0, '0);
        chk("lat_count", 64'(count), 64'd0);

        // Fill under backpressure, fifth push ignored, drain in order
        for (int k = 1; k <= 4; k++)
            cycle(1'b1, AW'(k), DW'(32'h100 + k), 1'b0, 1'b0, '0, '0);
        chk("full_count", 64'(count), 64'd4);
        chk("full_ready", 64'(bus.in_ready), 64'd0);
        cycle(1'b1, 5'd9, 32'hDEAD, 1'b0, 1'b0, '0, '0);
        chk("full_hold", 64'(count), 64'd4);
        for (int k = 1; k <= 4; k++) begin
            chk("order", 64'(bus.rf_waddr), 64'(k));
            cycle(1'b0, '0, '0, 1'b1, 1'b0, '0, '0);
        end
        chk("drained", 64'(count), 64'd0);

        // Full with push&pop pops only; push&pop at 2 keeps count across wrap
        for (int k = 1; k <= 4; k++)
            cycle(1'b1, AW'(k + 10), DW'(32'h200 + k), 1'b0, 1'b0, '0, '0);
        cycle(1'b1, 5'd20, 32'h2020, 1'b1, 1'b0, '0, '0);
        chk("full_pp", 64'(count), 64'd3);
        cycle(1'b0, '0, '0, 1'b1, 1'b0, '0, '0);
        cycle(1'b1, 5'd21, 32'h2121, 1'b1, 1'b0, '0, '0);
        chk("pp_hold", 64'(count), 64'd2);
        chk("pp_head", 64'(bus.rf_waddr), 64'd14);
        repeat (3) cycle(1'b0, '0, '0, 1'b1, 1'b0, '0, '0);

        // x0 destination is accepted but dropped
        cycle(1'b1, 5'd0, 32'hFFFF_FFFF, 1'b0, 1'b0, '0, '0);
        chk("x0_count", 64'(count), 64'd0);
        chk("x0_we",    64'(bus.rf_we), 64'd0);

        // Hazard detection and flush
        cycle(1'b1, 5'd7, 32'h7777, 1'b0, 1'b0, '0, '0);
        hz_rs1 = 5'd7;
        #1;
        chk("hz_rs1", 64'(hz_stall), 64'd1);
        hz_rs1 = 5'd0;
        hz_rs2 = 5'd7;
        #1;
        chk("hz_rs2", 64'(hz_stall), 64'd1);
        hz_rs2 = 5'd0;
        #1;
        chk("hz_zero", 64'(hz_stall), 64'd0);
        cycle(1'b1, 5'd8, 32'h8888, 1'b1, 1'b1, 5'd7, 5'd0);
        chk("fl_stall", 64'(hz_stall), 64'd0);
        chk("fl_count", 64'(count), 64'd0);

        // Asynchronous reset with three entries queued
        for (int k = 1; k <= 3; k++)
            cycle(1'b1, AW'(k + 2), DW'(k), 1'b0, 1'b0, '0, '0);
        rst = 1'b1;
        #1;
        chk("rst_we",    64'(bus.rf_we), 64'd0);
        chk("rst_count", 64'(count), 64'd0);
        chk("rst_ready", 64'(bus.in_ready), 64'd1);
        q.delete();
        @(negedge clk);
        rst = 1'b0;
        #1;

        // Randomized traffic with occasional flush and a small register set for hazards
        for (int n = 0; n < 3000; n++) begin
            logic          v;
            logic          rdy;
            logic          fl;
            logic [AW-1:0] rd;
            logic [AW-1:0] r1;
            logic [AW-1:0] r2;
            v   = ($urandom_range(0, 9) < 6);
            rdy = ((n / 40) % 2 == 0) ? ($urandom_range(0, 9) < 7) : ($urandom_range(0, 9) < 3);
            fl  = ($urandom_range(0, 99) < 3);
            rd  = AW'($urandom_range(0, 7));
            r1  = AW'($urandom_range(0, 7));
            r2  = AW'($urandom_range(0, 7));
            cycle(v, rd, $urandom, rdy, fl, r1, r2);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
